// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one split-transaction memory port between instruction fetch
// (port I) and the EX load/store path (port D). Request phases are arbitrated; owners of
// accepted requests are queued in an in-order FIFO so responses are steered back.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate grants on simultaneous requests).
module mem_port_arbiter #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic              clk,
   input  logic              rst_b,
   // instruction fetch port
   input  logic              iram_req,
   input  logic [XLEN-1:0]   iram_addr,
   output logic              iram_addr_ok,
   output logic              iram_data_ok,
   output logic [XLEN-1:0]   iram_rdata,
   // EX load/store port
   input  logic              dram_req,
   input  logic              dram_write,
   input  logic [XLEN/8-1:0] dram_wstrb,
   input  logic [XLEN-1:0]   dram_addr,
   input  logic [XLEN-1:0]   dram_wdata,
   output logic              dram_addr_ok,
   output logic              dram_data_ok,
   output logic [XLEN-1:0]   dram_rdata,
   // unified memory port
   output logic              mem_req,
   output logic              mem_write,
   output logic [XLEN/8-1:0] mem_wstrb,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              arb_err
);

   localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned CntW = $clog2(MAX_OUTST) + 1;
   localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTST);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTST - 1);

   // Owner encoding: 0 = port I, 1 = port D.
   logic [MAX_OUTST-1:0] owner_q, owner_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 lock_q, lock_d;
   logic                 lock_own_q, lock_own_d;
   logic                 arb_err_q, arb_err_d;
`ifdef ARB_ROUND_ROBIN_EN
   logic                 rr_last_q, rr_last_d;
`endif

   logic grant;
   logic not_full;
   logic push;
   logic pop;
   logic head_own;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   // Grant selection: locked owner wins, otherwise arbitrate between live requests.
   always_comb begin
      grant = 1'b0;
      if (lock_q) begin
         grant = lock_own_q;
      end else if (iram_req && dram_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         grant = ~rr_last_q;
`else
         grant = 1'b1;
`endif
      end else begin
         grant = dram_req;
      end
   end

   // Request-phase outputs and payload mux; full gating uses the registered count only.
   always_comb begin
      not_full     = (cnt_q < MaxCnt);
      mem_req      = (iram_req | dram_req) & not_full;
      push         = mem_req & mem_addr_ok;
      iram_addr_ok = push & ~grant;
      dram_addr_ok = push & grant;
      mem_write    = 1'b0;
      mem_wstrb    = '0;
      mem_addr     = iram_addr;
      mem_wdata    = '0;
      if (grant) begin
         mem_write = dram_write;
         mem_wstrb = dram_wstrb;
         mem_addr  = dram_addr;
         mem_wdata = dram_wdata;
      end
   end

   // Response routing to the owner at the FIFO head; stray responses are dropped.
   always_comb begin
      head_own     = owner_q[rd_ptr_q];
      pop          = mem_data_ok & (cnt_q != '0);
      iram_data_ok = pop & ~head_own;
      dram_data_ok = pop & head_own;
      iram_rdata   = iram_data_ok ? mem_rdata : '0;
      dram_rdata   = dram_data_ok ? mem_rdata : '0;
      arb_err      = arb_err_q;
   end

   // Next-state for owner FIFO, lock, error flag and round-robin history.
   always_comb begin
      owner_d    = owner_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      lock_d     = lock_q;
      lock_own_d = lock_own_q;
      arb_err_d  = arb_err_q;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_d  = rr_last_q;
      if (push) begin
         rr_last_d = grant;
      end
`endif
      if (push) begin
         owner_d[wr_ptr_q] = grant;
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      // A stalled request pins the grant until the memory accepts it.
      if (mem_req) begin
         if (mem_addr_ok) begin
            lock_d = 1'b0;
         end else begin
            lock_d     = 1'b1;
            lock_own_d = grant;
         end
      end
      if (mem_data_ok && (cnt_q == '0)) begin
         arb_err_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         owner_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         lock_q     <= 1'b0;
         lock_own_q <= 1'b0;
         arb_err_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_last_q  <= 1'b0;
`endif
      end else begin
         owner_q    <= owner_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         lock_q     <= lock_d;
         lock_own_q <= lock_own_d;
         arb_err_q  <= arb_err_d;
`ifdef ARB_ROUND_ROBIN_EN
         rr_last_q  <= rr_last_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and the memory,
// queues the expected owner of every accepted request and checks response routing.
module tb_mem_port_arbiter;

   localparam int unsigned XLEN = 32;

   logic              clk = 1'b0;
   logic              rst_b;
   logic              iram_req;
   logic [XLEN-1:0]   iram_addr;
   logic              iram_addr_ok;
   logic              iram_data_ok;
   logic [XLEN-1:0]   iram_rdata;
   logic              dram_req;
   logic              dram_write;
   logic [XLEN/8-1:0] dram_wstrb;
   logic [XLEN-1:0]   dram_addr;
   logic [XLEN-1:0]   dram_wdata;
   logic              dram_addr_ok;
   logic              dram_data_ok;
   logic [XLEN-1:0]   dram_rdata;
   logic              mem_req;
   logic              mem_write;
   logic [XLEN/8-1:0] mem_wstrb;
   logic [XLEN-1:0]   mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_addr_ok;
   logic              mem_data_ok;
   logic [XLEN-1:0]   mem_rdata;
   logic              arb_err;

   int total = 0;
   int bad   = 0;
   bit own_q[$];  // expected owner of each outstanding request, 0 = I, 1 = D

   always #5 clk = ~clk;

   mem_port_arbiter #(.XLEN(XLEN), .MAX_OUTST(2)) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .iram_req    (iram_req),
      .iram_addr   (iram_addr),
      .iram_addr_ok(iram_addr_ok),
      .iram_data_ok(iram_data_ok),
      .iram_rdata  (iram_rdata),
      .dram_req    (dram_req),
      .dram_write  (dram_write),
      .dram_wstrb  (dram_wstrb),
      .dram_addr   (dram_addr),
      .dram_wdata  (dram_wdata),
      .dram_addr_ok(dram_addr_ok),
      .dram_data_ok(dram_data_ok),
      .dram_rdata  (dram_rdata),
      .mem_req     (mem_req),
      .mem_write   (mem_write),
      .mem_wstrb   (mem_wstrb),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_addr_ok (mem_addr_ok),
      .mem_data_ok (mem_data_ok),
      .mem_rdata   (mem_rdata),
      .arb_err     (arb_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus after the falling edge, then settle for sampling.
   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dwd, input logic aok,
                        input logic dok, input logic [31:0] rd);
      @(negedge clk);
      iram_req    = ir;
      iram_addr   = ia;
      dram_req    = dr;
      dram_write  = dw;
      dram_wstrb  = dw ? 4'hF : 4'h0;
      dram_addr   = da;
      dram_wdata  = dwd;
      mem_addr_ok = aok;
      mem_data_ok = dok;
      mem_rdata   = rd;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic respond(input logic [31:0] rd);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, rd);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_b = 1'b0;
      iram_req = 1'b0; dram_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      own_q.delete();
      #1;
   endtask

   // Current cycle must accept the request of 'own' with that port's payload.
   task automatic exp_accept(input string tag, input bit own);
      chk({tag, "_mem_req"}, mem_req, 1);
      chk({tag, "_iaok"}, iram_addr_ok, own ? 0 : 1);
      chk({tag, "_daok"}, dram_addr_ok, own ? 1 : 0);
      chk({tag, "_addr"}, mem_addr, own ? dram_addr : iram_addr);
      chk({tag, "_write"}, mem_write, own ? dram_write : 1'b0);
      chk({tag, "_wstrb"}, mem_wstrb, own ? dram_wstrb : 4'h0);
      chk({tag, "_wdata"}, mem_wdata, own ? dram_wdata : 32'h0);
      own_q.push_back(own);
   endtask

   task automatic exp_no_accept(input string tag, input logic req);
      chk({tag, "_mem_req"}, mem_req, req);
      chk({tag, "_iaok"}, iram_addr_ok, 0);
      chk({tag, "_daok"}, dram_addr_ok, 0);
   endtask

   // Current cycle carries mem_data_ok with data rd for the oldest queued owner.
   task automatic exp_resp(input string tag, input logic [31:0] rd);
      bit own;
      chk({tag, "_sb_nonempty"}, (own_q.size() > 0), 1);
      if (own_q.size() > 0) begin
         own = own_q.pop_front();
         chk({tag, "_idok"}, iram_data_ok, own ? 0 : 1);
         chk({tag, "_ddok"}, dram_data_ok, own ? 1 : 0);
         chk({tag, "_irdata"}, iram_rdata, own ? 32'h0 : rd);
         chk({tag, "_drdata"}, dram_rdata, own ? rd : 32'h0);
      end
   endtask

   task automatic exp_no_resp(input string tag);
      chk({tag, "_idok"}, iram_data_ok, 0);
      chk({tag, "_ddok"}, dram_data_ok, 0);
   endtask

   initial begin
      bit own;
      rst_b = 1'b0;
      iram_req = 1'b0; iram_addr = '0; dram_req = 1'b0; dram_write = 1'b0; dram_wstrb = '0;
      dram_addr = '0; dram_wdata = '0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
      do_reset();

      // Reset state
      idle();
      exp_no_accept("rst", 0);
      exp_no_resp("rst");
      chk("rst_arb_err", arb_err, 0);

      // 1: single IF read, response two cycles after acceptance
      drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("t1_acc", 0);
      idle();
      exp_no_accept("t1_gap", 0);
      exp_no_resp("t1_gap");
      respond(32'hDEADBEEF);
      exp_resp("t1_resp", 32'hDEADBEEF);

      // 2: simultaneous requests, D first then I; responses D then I
      drive(1'b1, 32'h200, 1'b1, 1'b1, 32'h204, 32'hCAFE0001, 1'b1, 1'b0, 32'h0);
      exp_accept("t2_accD", 1);
      drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("t2_accI", 0);
      respond(32'hA1A1A1A1);
      exp_resp("t2_respD", 32'hA1A1A1A1);
      respond(32'hA2A2A2A2);
      exp_resp("t2_respI", 32'hA2A2A2A2);

      // 3: stalled IF request keeps the grant while D arrives
      drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      exp_no_accept("t3_stall1", 1);
      chk("t3_stall1_addr", mem_addr, 32'h300);
      drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h340, 32'h0, 1'b0, 1'b0, 32'h0);
      exp_no_accept("t3_stall2", 1);
      chk("t3_stall2_addr", mem_addr, 32'h300);
      drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h340, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("t3_stall3_addr", mem_addr, 32'h300);
      drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h340, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("t3_accI", 0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h340, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("t3_accD", 1);
      respond(32'h33330001);
      exp_resp("t3_respI", 32'h33330001);
      respond(32'h33330002);
      exp_resp("t3_respD", 32'h33330002);

      // 4: full FIFO blocks requests until a response drains it
      drive(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("t4_acc1", 0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h440, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("t4_acc2", 1);
      drive(1'b1, 32'h408, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_no_accept("t4_full", 0);
      drive(1'b1, 32'h408, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h44440001);
      exp_no_accept("t4_popcyc", 0);
      exp_resp("t4_resp1", 32'h44440001);
      drive(1'b1, 32'h408, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("t4_reacc", 0);
      respond(32'h44440002);
      exp_resp("t4_resp2", 32'h44440002);
      respond(32'h44440003);
      exp_resp("t4_resp3", 32'h44440003);

      // 5: push and pop in the same cycle at count 1, across several pointer wraps
      drive(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("t5_acc0", 0);
      for (int k = 0; k < 6; k++) begin
         own = (k % 2 == 0);
         drive(!own, 32'h600 + k * 4, own, 1'b1, 32'h680 + k * 4, 32'h5000 + k, 1'b1, 1'b1,
               32'h1000 + k);
         exp_resp($sformatf("t5_resp%0d", k), 32'h1000 + k);
         exp_accept($sformatf("t5_acc%0d", k + 1), own);
      end
      drive(1'b1, 32'h6F0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("t5_acc_last", 0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h6F4, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_no_accept("t5_full", 0);
      respond(32'h55550001);
      exp_resp("t5_drain1", 32'h55550001);
      respond(32'h55550002);
      exp_resp("t5_drain2", 32'h55550002);

      // 6: stray response sets a sticky error cleared only by reset
      respond(32'h00000055);
      exp_no_resp("t6_stray");
      chk("t6_err_before", arb_err, 0);
      idle();
      chk("t6_err_set", arb_err, 1);
      repeat (3) idle();
      chk("t6_err_sticky", arb_err, 1);
      do_reset();
      chk("t6_err_clr", arb_err, 0);

      // Reset mid-transaction drops the owner; its late response is an error
      drive(1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("t6_mid_acc", 0);
      do_reset();
      respond(32'h99999999);
      exp_no_resp("t6_late");
      idle();
      chk("t6_late_err", arb_err, 1);
      do_reset();

      // Continuous dual requests: fixed priority always D, round robin alternates D,I,D,I
      drive(1'b1, 32'h700, 1'b1, 1'b0, 32'h800, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_accept("dual_acc0", 1);
      for (int k = 1; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         own = (k % 2 == 0);
`else
         own = 1'b1;
`endif
         drive(1'b1, 32'h700, 1'b1, 1'b0, 32'h800, 32'h0, 1'b1, 1'b1, 32'h2000 + k);
         exp_resp($sformatf("dual_resp%0d", k), 32'h2000 + k);
         exp_accept($sformatf("dual_acc%0d", k), own);
      end
      respond(32'h20000009);
      exp_resp("dual_drain", 32'h20000009);
      idle();
      chk("final_err", arb_err, 0);
      chk("final_sb_empty", own_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
